lookup_cfg_writer: RTL and testbench
====================================

// Module: lookup_cfg_writer
// PURPOSE
//  Control-plane initiator for one match-action stage. Accepts 64b config beats, assembles a 1024b
//  CAM entry + 1024b mask or a 25b action word, and issues single-cycle write strobes on the stage
//  lookup/action write channels. Sits between the config stream demux and the stage lookup engine.
// PARAMETERS
//  STAGE      0     stage id this instance answers to; packets for other stages are consumed and dropped
//  DIN_WIDTH  1024  CAM entry / mask width; must be a multiple of 64 (BEATS = DIN_WIDTH/64 = 16)
//  ACT_WIDTH  25    action word width
// PORTS
//  clk              in   1          clock
//  rst_n            in   1          async active-low reset
//  cfg_data         in   64         config beat
//  cfg_valid        in   1          beat valid
//  cfg_last         in   1          last beat of packet
//  cfg_ready        out  1          beat accepted when cfg_valid & cfg_ready
//  lookup_din       out  DIN_WIDTH  CAM entry data
//  lookup_din_mask  out  DIN_WIDTH  CAM entry mask
//  lookup_din_addr  out  4          CAM entry address
//  lookup_din_en    out  1          CAM write strobe (1 cycle)
//  action_data_in   out  ACT_WIDTH  action word
//  action_addr      out  4          action RAM address
//  action_en        out  1          action write strobe (1 cycle)
//  err_cnt          out  8          malformed-packet counter, saturates at 8'hFF
// BEHAVIOUR
//  Reset: all outputs 0 (cfg_ready 0), state IDLE, beat counter 0. Async reset mid-packet discards partial data.
//  Header (beat 0): [63:56] opcode (8'h01 CAM write, 8'h02 action write), [55:52] stage, [51:48] addr; rest ignored.
//  FSM: IDLE, LOAD_KEY, LOAD_MASK, LOAD_ACT, COMMIT, DROP. cfg_ready=1 in all states except COMMIT.
//  IDLE: on accepted header with last=0: stage==STAGE & op 01 -> LOAD_KEY; op 02 -> LOAD_ACT;
//   stage!=STAGE -> DROP (no error); stage==STAGE & unknown op -> DROP, err_cnt+1.
//   Header with last=1: stay IDLE; err_cnt+1 only if stage==STAGE.
//  LOAD_KEY: beat i (0..BEATS-1) -> lookup_din[64*i +: 64]; after BEATS beats -> LOAD_MASK.
//  LOAD_MASK: beat i -> lookup_din_mask[64*i +: 64]; on beat BEATS-1 with last=1 -> COMMIT.
//  LOAD_ACT: one beat, action_data_in <= cfg_data[ACT_WIDTH-1:0]; last=1 -> COMMIT.
//  Framing errors: last=1 before the final expected beat -> IDLE, no strobe, err_cnt+1;
//   last=0 on final expected beat -> DROP, no strobe, err_cnt+1.
//  COMMIT: exactly one cycle; lookup_din_en or action_en =1 per opcode; addr outputs hold header addr
//   from header acceptance until the next accepted header; data/mask regs hold until overwritten.
//   Strobe asserted the cycle after the final beat is accepted; then IDLE. Strobes never both high.
//  DROP: accept and discard beats until accepted beat with last=1, then IDLE.
//  cfg_valid low mid-packet: state and beat counter hold (arbitrary bubbles allowed).
//  Beat counter resets to 0 on every state transition; lookup_din is not cleared between packets.
//  Throughput: CAM write = 1+2*BEATS beats + 1 commit cycle; back-to-back packets accepted after COMMIT.
// TESTING
//  CAM write STAGE, addr 5, key beats 64'h1000+i, mask beats ~0 -> lookup_din_en 1 cycle after beat 32,
//   addr 5, lookup_din[63:0]=64'h1000, [1023:960]=64'h100F, mask all 1s, action_en stays 0.
//  Action write addr 3, data 64'h1ABCDEF -> action_en 1 cycle, action_data_in=25'h1ABCDEF, action_addr 3.
//  Header stage=STAGE+1, 33 beats -> all beats consumed, no strobes, err_cnt unchanged.
//  CAM write with last=1 on mask beat 7 -> no strobe, err_cnt=1, next valid action write commits normally.
//  Random cfg_valid gaps (50%) during CAM write -> identical lookup_din/mask and single strobe as gap-free.
//  Assert rst_n low after key beat 8, release, send action write -> only action_en fires; err_cnt 0.

Source files
------------

// File: rtl/lookup_cfg_writer.sv
// Config-stream writer for one match-action stage: assembles CAM key/mask or action
// words from 64b beats and pulses a one-cycle write strobe toward the lookup engine.
module lookup_cfg_writer #(
    parameter int STAGE     = 0,
    parameter int DIN_WIDTH = 1024,
    parameter int ACT_WIDTH = 25
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [63:0]          cfg_data,
    input  logic                 cfg_valid,
    input  logic                 cfg_last,
    output logic                 cfg_ready,
    output logic [DIN_WIDTH-1:0] lookup_din,
    output logic [DIN_WIDTH-1:0] lookup_din_mask,
    output logic [3:0]           lookup_din_addr,
    output logic                 lookup_din_en,
    output logic [ACT_WIDTH-1:0] action_data_in,
    output logic [3:0]           action_addr,
    output logic                 action_en,
    output logic [7:0]           err_cnt
);

    localparam int BEATS = DIN_WIDTH / 64;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [7:0] OP_CAM = 8'h01;
    localparam logic [7:0] OP_ACT = 8'h02;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_KEY,
        ST_LOAD_MASK,
        ST_LOAD_ACT,
        ST_COMMIT,
        ST_DROP
    } state_t;

    state_t                 state_reg, state_next;
    logic [CNT_W-1:0]       beat_reg, beat_next;
    logic                   op_cam_reg, op_cam_next;
    logic                   ready_reg;
    logic                   din_en_reg, act_en_reg;
    logic [3:0]             din_addr_reg, act_addr_reg;
    logic [ACT_WIDTH-1:0]   act_data_reg;
    logic [7:0]             err_cnt_reg;

    logic                   accept;
    logic                   hdr_load;
    logic                   key_we, mask_we, act_we;
    logic                   err_inc;

    logic [7:0]             hdr_op;
    logic [3:0]             hdr_stage;
    logic [3:0]             hdr_addr;
    logic                   hdr_ours;

    assign accept    = cfg_valid & ready_reg;
    assign hdr_op    = cfg_data[63:56];
    assign hdr_stage = cfg_data[55:52];
    assign hdr_addr  = cfg_data[51:48];
    assign hdr_ours  = (hdr_stage == 4'(STAGE));

    always_comb begin
        state_next  = state_reg;
        beat_next   = beat_reg;
        op_cam_next = op_cam_reg;
        hdr_load    = 1'b0;
        key_we      = 1'b0;
        mask_we     = 1'b0;
        act_we      = 1'b0;
        err_inc     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    hdr_load    = 1'b1;
                    op_cam_next = (hdr_op == OP_CAM);
                    if (hdr_ours) begin
                        // A header that is also the last beat carries no payload at all
                        if (cfg_last) begin
                            err_inc = 1'b1;
                        end else if (hdr_op == OP_CAM) begin
                            state_next = ST_LOAD_KEY;
                        end else if (hdr_op == OP_ACT) begin
                            state_next = ST_LOAD_ACT;
                        end else begin
                            state_next = ST_DROP;
                            err_inc    = 1'b1;
                        end
                    end else if (!cfg_last) begin
                        state_next = ST_DROP;
                    end
                end
            end

            ST_LOAD_KEY: begin
                if (accept) begin
                    key_we = 1'b1;
                    if (cfg_last) begin
                        state_next = ST_IDLE;
                        err_inc    = 1'b1;
                    end else if (beat_reg == LAST_BEAT) begin
                        state_next = ST_LOAD_MASK;
                    end else begin
                        beat_next = beat_reg + CNT_W'(1);
                    end
                end
            end

            ST_LOAD_MASK: begin
                if (accept) begin
                    mask_we = 1'b1;
                    if (beat_reg == LAST_BEAT) begin
                        if (cfg_last) begin
                            state_next = ST_COMMIT;
                        end else begin
                            state_next = ST_DROP;
                            err_inc    = 1'b1;
                        end
                    end else if (cfg_last) begin
                        state_next = ST_IDLE;
                        err_inc    = 1'b1;
                    end else begin
                        beat_next = beat_reg + CNT_W'(1);
                    end
                end
            end

            ST_LOAD_ACT: begin
                if (accept) begin
                    act_we = 1'b1;
                    if (cfg_last) begin
                        state_next = ST_COMMIT;
                    end else begin
                        state_next = ST_DROP;
                        err_inc    = 1'b1;
                    end
                end
            end

            ST_COMMIT: begin
                state_next = ST_IDLE;
            end

            ST_DROP: begin
                if (accept && cfg_last) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (state_next != state_reg) begin
            beat_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            beat_reg     <= '0;
            op_cam_reg   <= 1'b0;
            ready_reg    <= 1'b0;
            din_en_reg   <= 1'b0;
            act_en_reg   <= 1'b0;
            din_addr_reg <= '0;
            act_addr_reg <= '0;
            act_data_reg <= '0;
            err_cnt_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            beat_reg   <= beat_next;
            op_cam_reg <= op_cam_next;
            // Registered so the port reads 0 during reset and drops exactly for the commit cycle
            ready_reg  <= (state_next != ST_COMMIT);
            din_en_reg <= (state_next == ST_COMMIT) &&  op_cam_reg;
            act_en_reg <= (state_next == ST_COMMIT) && !op_cam_reg;
            if (hdr_load) begin
                din_addr_reg <= hdr_addr;
                act_addr_reg <= hdr_addr;
            end
            if (act_we) begin
                act_data_reg <= cfg_data[ACT_WIDTH-1:0];
            end
            if (err_inc && (err_cnt_reg != 8'hFF)) begin
                err_cnt_reg <= err_cnt_reg + 8'd1;
            end
        end
    end

    // One 64b key word and one 64b mask word per beat slot
    generate
        for (genvar gi = 0; gi < BEATS; gi++) begin : g_word
            logic [63:0] key_word_reg;
            logic [63:0] mask_word_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    key_word_reg  <= '0;
                    mask_word_reg <= '0;
                end else begin
                    if (key_we && (beat_reg == CNT_W'(gi))) begin
                        key_word_reg <= cfg_data;
                    end
                    if (mask_we && (beat_reg == CNT_W'(gi))) begin
                        mask_word_reg <= cfg_data;
                    end
                end
            end

            assign lookup_din[64*gi +: 64]      = key_word_reg;
            assign lookup_din_mask[64*gi +: 64] = mask_word_reg;
        end
    endgenerate

    assign cfg_ready       = ready_reg;
    assign lookup_din_addr = din_addr_reg;
    assign lookup_din_en   = din_en_reg;
    assign action_data_in  = act_data_reg;
    assign action_addr     = act_addr_reg;
    assign action_en       = act_en_reg;
    assign err_cnt         = err_cnt_reg;

endmodule

// File: tb/tb_lookup_cfg_writer.sv
// Bench for lookup_cfg_writer: directed packets plus random packets scored against a
// packet-level model (a packet is judged only by its stage, opcode and length).
module tb_lookup_cfg_writer;

    localparam int STAGE = 0;
    localparam int DW    = 1024;
    localparam int AW    = 25;
    localparam int BEATS = DW / 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [63:0]   cfg_data;
    logic          cfg_valid;
    logic          cfg_last;
    logic          cfg_ready;
    logic [DW-1:0] lookup_din;
    logic [DW-1:0] lookup_din_mask;
    logic [3:0]    lookup_din_addr;
    logic          lookup_din_en;
    logic [AW-1:0] action_data_in;
    logic [3:0]    action_addr;
    logic          action_en;
    logic [7:0]    err_cnt;

    lookup_cfg_writer #(.STAGE(STAGE), .DIN_WIDTH(DW), .ACT_WIDTH(AW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cfg_data        (cfg_data),
        .cfg_valid       (cfg_valid),
        .cfg_last        (cfg_last),
        .cfg_ready       (cfg_ready),
        .lookup_din      (lookup_din),
        .lookup_din_mask (lookup_din_mask),
        .lookup_din_addr (lookup_din_addr),
        .lookup_din_en   (lookup_din_en),
        .action_data_in  (action_data_in),
        .action_addr     (action_addr),
        .action_en       (action_en),
        .err_cnt         (err_cnt)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    int cam_strobes = 0;
    int act_strobes = 0;
    int both_high   = 0;

    int            exp_cam_total = 0;
    int            exp_act_total = 0;
    logic [7:0]    exp_err = 8'd0;
    logic [DW-1:0] exp_din;
    logic [DW-1:0] exp_mask;
    logic [3:0]    exp_din_addr;
    logic [3:0]    exp_act_addr;
    logic [AW-1:0] exp_act;
    logic          exp_cam_now;
    logic          exp_act_now;

    logic [63:0]   pkt[$];
    logic [DW-1:0] saved_din;
    logic [DW-1:0] saved_mask;

    always @(negedge clk) begin
        if (rst_n) begin
            if (lookup_din_en)              cam_strobes++;
            if (action_en)                  act_strobes++;
            if (lookup_din_en && action_en) both_high++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_wide(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        int idx;
        idx = 0;
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            for (int i = BEATS - 1; i >= 0; i--)
                if (obs[64*i +: 64] !== exp[64*i +: 64]) idx = i;
            $error("FAIL %s: word %0d observed %0h expected %0h", tag, idx,
                   obs[64*idx +: 64], exp[64*idx +: 64]);
        end
    endtask

    function automatic logic [63:0] hdr(input logic [7:0] op, input logic [3:0] st, input logic [3:0] ad);
        logic [63:0] r;
        r = {$urandom, $urandom};
        return {op, st, ad, r[47:0]};
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Entered and left at posedge+1; the beat is taken at the first edge where ready was high.
    task automatic send_beat(input logic [63:0] d, input logic l, input int gap_pct);
        int  n;
        bit  took;
        n = 0;
        while (n < 8 && int'($urandom_range(99)) < gap_pct) begin
            cfg_valid = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        cfg_data  = d;
        cfg_last  = l;
        cfg_valid = 1'b1;
        took = 1'b0;
        for (int t = 0; t < 20 && !took; t++) begin
            took = cfg_ready;
            @(posedge clk); #1;
        end
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
        if (!took) check("beat_accept_timeout", 64'(took), 64'd1);
    endtask

    // Packet-level reference: a packet for this stage is good only if it is a CAM write of
    // exactly 1+2*BEATS beats or an action write of exactly 2 beats; anything else is one error.
    task automatic model_packet();
        logic [7:0] op;
        logic       ours;
        int         len;
        op   = pkt[0][63:56];
        ours = (pkt[0][55:52] == 4'(STAGE));
        len  = pkt.size();
        exp_cam_now = ours && (op == 8'h01) && (len == 1 + 2 * BEATS);
        exp_act_now = ours && (op == 8'h02) && (len == 2);
        if (ours && !exp_cam_now && !exp_act_now && exp_err != 8'hFF) exp_err++;
        if (exp_cam_now) begin
            for (int i = 0; i < BEATS; i++) begin
                exp_din[64*i +: 64]  = pkt[1 + i];
                exp_mask[64*i +: 64] = pkt[1 + BEATS + i];
            end
            exp_din_addr = pkt[0][51:48];
            exp_cam_total++;
        end
        if (exp_act_now) begin
            exp_act      = pkt[1][AW-1:0];
            exp_act_addr = pkt[0][51:48];
            exp_act_total++;
        end
    endtask

    task automatic send_packet(input int gap_pct);
        for (int i = 0; i < pkt.size(); i++)
            send_beat(pkt[i], (i == pkt.size() - 1), gap_pct);
        model_packet();
        check("lookup_din_en", 64'(lookup_din_en), 64'(exp_cam_now));
        check("action_en", 64'(action_en), 64'(exp_act_now));
        check("err_cnt", 64'(err_cnt), 64'(exp_err));
        if (exp_cam_now) begin
            check_wide("lookup_din", lookup_din, exp_din);
            check_wide("lookup_din_mask", lookup_din_mask, exp_mask);
            check("lookup_din_addr", 64'(lookup_din_addr), 64'(exp_din_addr));
        end
        if (exp_act_now) begin
            check("action_data_in", 64'(action_data_in), 64'(exp_act));
            check("action_addr", 64'(action_addr), 64'(exp_act_addr));
        end
        if (exp_cam_now || exp_act_now) begin
            check("cfg_ready_in_commit", 64'(cfg_ready), 64'd0);
            @(posedge clk); #1;
            check("strobe_single_cycle", {62'd0, lookup_din_en, action_en}, 64'd0);
        end
    endtask

    task automatic build_cam(input logic [3:0] ad);
        pkt = {};
        pkt.push_back(hdr(8'h01, 4'(STAGE), ad));
        for (int i = 0; i < 2 * BEATS; i++) pkt.push_back(rnd64());
    endtask

    task automatic build_random();
        int          kind;
        int          len;
        logic [7:0]  op;
        logic [3:0]  st;
        logic [3:0]  ad;
        kind = int'($urandom_range(7));
        st   = 4'(STAGE);
        ad   = 4'($urandom_range(15));
        case (kind)
            0, 1: begin op = 8'h01; len = 1 + 2 * BEATS; end
            2:    begin op = 8'h02; len = 2; end
            3:    begin op = 8'($urandom_range(1, 2)); st = 4'(STAGE + int'($urandom_range(1, 15)));
                        len = int'($urandom_range(1, 40)); end
            4:    begin op = 8'h01; len = int'($urandom_range(1, 2 * BEATS)); end
            5:    begin op = 8'h01; len = int'($urandom_range(2 * BEATS + 2, 2 * BEATS + 4)); end
            6:    begin op = 8'h02; len = ($urandom_range(1) == 0) ? 1 : int'($urandom_range(3, 4)); end
            default: begin op = 8'($urandom_range(3, 255)); len = int'($urandom_range(1, 5)); end
        endcase
        pkt = {};
        pkt.push_back(hdr(op, st, ad));
        for (int i = 1; i < len; i++) pkt.push_back(rnd64());
    endtask

    initial begin
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
        cfg_data  = '0;
        exp_din   = '0;
        exp_mask  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_cfg_ready", 64'(cfg_ready), 64'd0);
        check("reset_strobes", {62'd0, lookup_din_en, action_en}, 64'd0);
        check("reset_err_cnt", 64'(err_cnt), 64'd0);
        check_wide("reset_lookup_din", lookup_din, '0);
        check("reset_action_data", 64'(action_data_in), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_reset", 64'(cfg_ready), 64'd1);

        // CAM write: key 0x1000+i, mask all ones, addr 5
        pkt = {};
        pkt.push_back(hdr(8'h01, 4'(STAGE), 4'd5));
        for (int i = 0; i < BEATS; i++) pkt.push_back(64'h1000 + 64'(i));
        for (int i = 0; i < BEATS; i++) pkt.push_back({64{1'b1}});
        send_packet(0);
        check("cam_key_word0", lookup_din[63:0], 64'h1000);
        check("cam_key_word15", lookup_din[DW-1 -: 64], 64'h100F);
        check("cam_addr", 64'(lookup_din_addr), 64'd5);
        check("cam_no_action_en", 64'(act_strobes), 64'd0);

        // Action write addr 3
        pkt = {};
        pkt.push_back(hdr(8'h02, 4'(STAGE), 4'd3));
        pkt.push_back(64'h1ABCDEF);
        send_packet(0);
        check("act_data", 64'(action_data_in), 64'h1ABCDEF);
        check("act_addr", 64'(action_addr), 64'd3);

        // Another stage's 33-beat packet is swallowed silently
        pkt = {};
        pkt.push_back(hdr(8'h01, 4'(STAGE + 1), 4'd7));
        for (int i = 0; i < 2 * BEATS; i++) pkt.push_back(rnd64());
        send_packet(0);
        check("other_stage_err", 64'(err_cnt), 64'd0);
        check("other_stage_cam_strobes", 64'(cam_strobes), 64'd1);
        check("other_stage_act_strobes", 64'(act_strobes), 64'd1);

        // Early last on mask beat 7, then a normal action write
        pkt = {};
        pkt.push_back(hdr(8'h01, 4'(STAGE), 4'd2));
        for (int i = 0; i < BEATS + 8; i++) pkt.push_back(rnd64());
        send_packet(0);
        check("early_last_err", 64'(err_cnt), 64'd1);
        check("early_last_no_strobe", 64'(cam_strobes), 64'd1);
        pkt = {};
        pkt.push_back(hdr(8'h02, 4'(STAGE), 4'd9));
        pkt.push_back(rnd64());
        send_packet(0);

        // Same CAM packet with 50% valid gaps, then gap-free
        build_cam(4'd11);
        send_packet(50);
        saved_din  = lookup_din;
        saved_mask = lookup_din_mask;
        send_packet(0);
        check_wide("gap_vs_nogap_din", lookup_din, saved_din);
        check_wide("gap_vs_nogap_mask", lookup_din_mask, saved_mask);

        for (int n = 0; n < 40; n++) begin
            build_random();
            send_packet(($urandom_range(1) == 0) ? 0 : 30);
        end

        // Reset in the middle of a CAM key load
        send_beat(hdr(8'h01, 4'(STAGE), 4'd6), 1'b0, 0);
        for (int i = 0; i <= 8; i++) send_beat(rnd64(), 1'b0, 0);
        rst_n = 1'b0;
        #2;
        check("midreset_ready", 64'(cfg_ready), 64'd0);
        check("midreset_err_cnt", 64'(err_cnt), 64'd0);
        check_wide("midreset_lookup_din", lookup_din, '0);
        exp_err = 8'd0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        pkt = {};
        pkt.push_back(hdr(8'h02, 4'(STAGE), 4'd4));
        pkt.push_back(rnd64());
        send_packet(0);
        check("post_reset_err_cnt", 64'(err_cnt), 64'd0);

        repeat (2) @(posedge clk);
        #1;
        check("total_cam_strobes", 64'(cam_strobes), 64'(exp_cam_total));
        check("total_act_strobes", 64'(act_strobes), 64'(exp_act_total));
        check("strobes_never_both", 64'(both_high), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
